// File: rtl/i2s_rx_ctrl_if.sv
// SoC-facing sample FIFO port of the I2S receive controller.
// master = SoC/firmware side, slave = i2s_rx_ctrl.
interface i2s_rx_ctrl_if #(
   parameter int DATA_W     = 24,
   parameter int FIFO_DEPTH = 8
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic              rd;
   logic [DATA_W-1:0] rdata;
   logic              rch;
   logic              empty;
   logic              full;
   logic [LVL_W-1:0]  level;
   logic [LVL_W-1:0]  fifo_thr;
   logic              irq;
   logic              overrun;
   logic              ovr_clr;

   modport master (
      output rd, fifo_thr, ovr_clr,
      input  rdata, rch, empty, full, level, irq, overrun
   );

   modport slave (
      input  rd, fifo_thr, ovr_clr,
      output rdata, rch, empty, full, level, irq, overrun
   );
endinterface

// File: rtl/i2s_rx_ctrl.sv
// I2S master receiver: generates sck/ws, deserialises I2S_in into a FWFT sample FIFO.
// Optional STEREO_EN: push both slots and report the channel on rch (default: left slot only).
module i2s_rx_ctrl #(
   parameter int CLK_DIV    = 4,
   parameter int DATA_W     = 24,
   parameter int FIFO_DEPTH = 8
) (
   input  logic         HCLK,
   input  logic         HRESETn,
   input  logic         en,
   output logic         i2s_clk,
   output logic         ws,
   input  logic         I2S_in,
   i2s_rx_ctrl_if.slave fifo_if
);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LW    = AW + 1;
   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
`ifdef STEREO_EN
   localparam int ENTRY_W = DATA_W + 1;
`else
   localparam int ENTRY_W = DATA_W;
`endif

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]        state;
   logic [DIV_W-1:0]  div_cnt;
   logic [5:0]        bcnt;
   logic [DATA_W-1:0] shreg;
   logic              push_pend;
`ifdef STEREO_EN
   logic              push_ch;
`endif

   logic [4:0] pos;
   logic       div_tc;
   logic       sck_rise;
   logic       sck_fall;
   logic       capture;
   logic       last_bit;
   logic       slot_ok;
   logic [5:0] bcnt_inc;

   assign pos      = bcnt[4:0];
   assign bcnt_inc = bcnt + 6'd1;
   assign div_tc   = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign sck_rise = en && div_tc && !i2s_clk;
   assign sck_fall = en && div_tc && i2s_clk;
   assign capture  = sck_rise && (pos != 5'd0) && (pos <= 5'(DATA_W));
   assign last_bit = sck_rise && (pos == 5'(DATA_W));
`ifdef STEREO_EN
   assign slot_ok  = 1'b1;
`else
   assign slot_ok  = !bcnt[5];
`endif

   // Bit clock, slot counter and deserialiser; dropping en aborts the frame at once.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= ST_IDLE;
         div_cnt   <= '0;
         i2s_clk   <= 1'b0;
         ws        <= 1'b0;
         bcnt      <= '0;
         shreg     <= '0;
         push_pend <= 1'b0;
`ifdef STEREO_EN
         push_ch   <= 1'b0;
`endif
      end else if (!en) begin
         state     <= ST_IDLE;
         div_cnt   <= '0;
         i2s_clk   <= 1'b0;
         ws        <= 1'b0;
         bcnt      <= '0;
         shreg     <= '0;
         push_pend <= 1'b0;
      end else begin
         state     <= ST_RUN;
         div_cnt   <= div_tc ? '0 : div_cnt + 1'b1;
         if (div_tc)
            i2s_clk <= ~i2s_clk;
         if (sck_fall) begin
            bcnt <= bcnt_inc;
            ws   <= bcnt_inc[5];
         end
         if (capture)
            shreg <= DATA_W'({shreg, I2S_in});
         push_pend <= last_bit && slot_ok;
`ifdef STEREO_EN
         if (last_bit)
            push_ch <= bcnt[5];
`endif
      end
   end

   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [ENTRY_W-1:0] head;
   logic [ENTRY_W-1:0] push_data;
   logic [LW-1:0]      wr_ptr;
   logic [LW-1:0]      rd_ptr;
   logic [LW-1:0]      wr_nxt;
   logic [LW-1:0]      rd_nxt;
   logic [LW-1:0]      lvl_nxt;
   logic               full_r;
   logic               irq_r;
   logic               ovr_r;
   logic               empty_w;
   logic               push_req;
   logic               push_ok;
   logic               pop;
   logic               drop;

`ifdef STEREO_EN
   assign push_data = {push_ch, shreg};
`else
   assign push_data = shreg;
`endif

   assign empty_w  = (wr_ptr == rd_ptr);
   assign push_req = push_pend && (state == ST_RUN);
   assign pop      = fifo_if.rd && !empty_w;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign push_ok  = push_req && (!full_r || pop);
   assign drop     = push_req && full_r && !pop;
   assign wr_nxt   = wr_ptr + LW'(push_ok);
   assign rd_nxt   = rd_ptr + LW'(pop);
   assign lvl_nxt  = wr_nxt - rd_nxt;

   always_ff @(posedge HCLK) begin
      if (push_ok)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end

   // Head register keeps rdata valid on the same edge as a push/pop; it holds while empty.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         head   <= '0;
         full_r <= 1'b0;
         irq_r  <= 1'b0;
         ovr_r  <= 1'b0;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         if (rd_nxt != wr_nxt)
            head <= (rd_nxt == wr_ptr) ? push_data : mem[rd_nxt[AW-1:0]];
         full_r <= (lvl_nxt == LW'(FIFO_DEPTH));
         irq_r  <= (fifo_if.fifo_thr != '0) && (lvl_nxt >= fifo_if.fifo_thr);
         if (drop)
            ovr_r <= 1'b1;
         else if (fifo_if.ovr_clr)
            ovr_r <= 1'b0;
      end
   end

   assign fifo_if.rdata   = head[DATA_W-1:0];
`ifdef STEREO_EN
   assign fifo_if.rch     = head[DATA_W];
`else
   assign fifo_if.rch     = 1'b0;
`endif
   assign fifo_if.empty   = empty_w;
   assign fifo_if.full    = full_r;
   assign fifo_if.level   = wr_ptr - rd_ptr;
   assign fifo_if.irq     = irq_r;
   assign fifo_if.overrun = ovr_r;
endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Directed bench for i2s_rx_ctrl (CLK_DIV=2): clocking, capture, threshold irq,
// overrun, push+pop at full, drain and abort/restart. Follows STEREO_EN if defined.
module tb_i2s_rx_ctrl;
   localparam int CLK_DIV    = 2;
   localparam int DATA_W     = 24;
   localparam int FIFO_DEPTH = 8;
`ifdef STEREO_EN
   localparam int STEREO = 1;
`else
   localparam int STEREO = 0;
`endif
   // HCLK edges between consecutive pushes (frame is 256 edges at CLK_DIV=2).
   localparam int S  = (STEREO != 0) ? 128 : 256;
   localparam int P0 = 99;

   logic HCLK    = 1'b0;
   logic HRESETn = 1'b0;
   logic en      = 1'b0;
   logic I2S_in  = 1'b0;
   logic i2s_clk;
   logic ws;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int base         = 0;
   int start_frame  = 0;
   logic [5:0] tb_bcnt  = 6'd0;
   int         tb_frame = 0;

   logic [23:0] word_l [16] = '{24'hA5A5A5, 24'h111111, 24'h222222, 24'h333333,
                                24'h444444, 24'h555555, 24'h666666, 24'h777777,
                                24'h888888, 24'h999999, 24'hAAAAAA, 24'hBBBBBB,
                                24'hC0FFEE, 24'hDDDDDD, 24'hEEEEEE, 24'hF0F0F0};
   logic [23:0] word_r [16] = '{24'h123456, 24'h0F0F0F, 24'h13579B, 24'h2468AC,
                                24'h00FF00, 24'hFF00FF, 24'h5A5A5A, 24'hDEADBE,
                                24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C,
                                24'hCAFE01, 24'hBEEF02, 24'h765432, 24'hFEDCBA};

   i2s_rx_ctrl_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) fifo_if ();

   i2s_rx_ctrl #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .en      (en),
      .i2s_clk (i2s_clk),
      .ws      (ws),
      .I2S_in  (I2S_in),
      .fifo_if (fifo_if)
   );

   always #5 HCLK = ~HCLK;

   always @(posedge HCLK) cyc <= cyc + 1;

   // Microphone model: presents bit for slot position p after the sck fall that makes bcnt=p.
   always begin
      @(posedge en);
      tb_bcnt  = 6'd0;
      tb_frame = start_frame;
      while (en) begin
         @(negedge i2s_clk or negedge en);
         if (en) begin
            logic [23:0] w;
            int p;
            tb_bcnt = tb_bcnt + 6'd1;
            if (tb_bcnt == 6'd0)
               tb_frame = tb_frame + 1;
            p = int'(tb_bcnt[4:0]);
            w = tb_bcnt[5] ? word_r[tb_frame % 16] : word_l[tb_frame % 16];
            if (p >= 1 && p <= DATA_W)
               I2S_in = w[DATA_W - p];
            else
               I2S_in = 1'($urandom_range(0, 1));
         end
      end
   end

   function automatic logic [23:0] exp_sample(input int m);
      if (STEREO != 0)
         return (m % 2 == 1) ? word_r[(m / 2) % 16] : word_l[(m / 2) % 16];
      return word_l[m % 16];
   endfunction

   function automatic logic exp_ch(input int m);
      return (STEREO != 0) && (m % 2 == 1);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Wait until the negedge following HCLK edge n counted from the last startRun.
   task automatic runTo(input int n);
      while (cyc - base < n)
         @(negedge HCLK);
   endtask

   task automatic startRun(input int frame);
      @(negedge HCLK);
      start_frame = frame;
      base        = cyc;
      en          = 1'b1;
   endtask

   // Hold rd/ovr_clr through edge n, then release them.
   task automatic applyStimulus(input logic rd_v, input logic clr_v, input int n);
      fifo_if.rd      = rd_v;
      fifo_if.ovr_clr = clr_v;
      runTo(n);
      fifo_if.rd      = 1'b0;
      fifo_if.ovr_clr = 1'b0;
   endtask

   initial begin
      int drain_order [7] = '{2, 3, 4, 5, 6, 7, 9};
      int t;

      fifo_if.rd       = 1'b0;
      fifo_if.ovr_clr  = 1'b0;
      fifo_if.fifo_thr = 4'd4;
      en               = 1'b1;

      repeat (5) begin
         @(negedge HCLK);
         checkOutput("rst_sck_static", 32'(i2s_clk), 32'd0);
      end
      checkOutput("rst_ws", 32'(ws), 32'd0);
      checkOutput("rst_rdata", 32'(fifo_if.rdata), 32'd0);
      checkOutput("rst_rch", 32'(fifo_if.rch), 32'd0);
      checkOutput("rst_empty", 32'(fifo_if.empty), 32'd1);
      checkOutput("rst_full", 32'(fifo_if.full), 32'd0);
      checkOutput("rst_level", 32'(fifo_if.level), 32'd0);
      checkOutput("rst_irq", 32'(fifo_if.irq), 32'd0);
      checkOutput("rst_overrun", 32'(fifo_if.overrun), 32'd0);

      en = 1'b0;
      @(negedge HCLK);
      HRESETn = 1'b1;

      startRun(0);
      runTo(1);   checkOutput("sck_before_first_rise", 32'(i2s_clk), 32'd0);
      runTo(2);   checkOutput("sck_first_rise", 32'(i2s_clk), 32'd1);
      runTo(4);   checkOutput("sck_first_fall", 32'(i2s_clk), 32'd0);
      runTo(6);   checkOutput("sck_period", 32'(i2s_clk), 32'd1);
      runTo(P0-1); checkOutput("cap_empty_before", 32'(fifo_if.empty), 32'd1);
      runTo(P0);
      checkOutput("cap_empty_after", 32'(fifo_if.empty), 32'd0);
      checkOutput("cap_level", 32'(fifo_if.level), 32'd1);
      checkOutput("cap_rdata", 32'(fifo_if.rdata), 32'h00A5A5A5);
      checkOutput("cap_rch", 32'(fifo_if.rch), 32'd0);
      runTo(127); checkOutput("ws_before_32", 32'(ws), 32'd0);
      runTo(128); checkOutput("ws_after_32", 32'(ws), 32'd1);
      runTo(227); checkOutput("right_slot_level", 32'(fifo_if.level), 32'(1 + STEREO));
      runTo(255); checkOutput("ws_before_64", 32'(ws), 32'd1);
      runTo(256); checkOutput("ws_after_64", 32'(ws), 32'd0);

      runTo(P0 + 3*S - 1);
      checkOutput("irq_below_thr", 32'(fifo_if.irq), 32'd0);
      checkOutput("level_3", 32'(fifo_if.level), 32'd3);
      runTo(P0 + 3*S);
      checkOutput("irq_at_thr", 32'(fifo_if.irq), 32'd1);
      checkOutput("level_4", 32'(fifo_if.level), 32'd4);

      runTo(P0 + 7*S);
      checkOutput("full_level", 32'(fifo_if.level), 32'd8);
      checkOutput("full_flag", 32'(fifo_if.full), 32'd1);
      checkOutput("full_no_ovr", 32'(fifo_if.overrun), 32'd0);
      runTo(P0 + 8*S);
      checkOutput("ovr_set", 32'(fifo_if.overrun), 32'd1);
      checkOutput("ovr_level", 32'(fifo_if.level), 32'd8);
      checkOutput("ovr_head", 32'(fifo_if.rdata), 32'(exp_sample(0)));
      applyStimulus(1'b0, 1'b1, P0 + 8*S + 1);
      checkOutput("ovr_clr", 32'(fifo_if.overrun), 32'd0);

      runTo(P0 + 9*S - 1);
      applyStimulus(1'b1, 1'b0, P0 + 9*S);
      checkOutput("pp_level", 32'(fifo_if.level), 32'd8);
      checkOutput("pp_full", 32'(fifo_if.full), 32'd1);
      checkOutput("pp_no_ovr", 32'(fifo_if.overrun), 32'd0);
      checkOutput("pp_head", 32'(fifo_if.rdata), 32'(exp_sample(1)));
      checkOutput("pp_rch", 32'(fifo_if.rch), 32'(exp_ch(1)));

      applyStimulus(1'b1, 1'b0, P0 + 9*S + 1);
      en = 1'b0;
      checkOutput("pop_level", 32'(fifo_if.level), 32'd7);
      checkOutput("pop_full", 32'(fifo_if.full), 32'd0);
      checkOutput("pop_head", 32'(fifo_if.rdata), 32'(exp_sample(2)));

      t = P0 + 9*S + 1;
      for (int i = 1; i < 7; i++) begin
         t++;
         applyStimulus(1'b1, 1'b0, t);
         checkOutput("drain_head", 32'(fifo_if.rdata), 32'(exp_sample(drain_order[i])));
         checkOutput("drain_rch", 32'(fifo_if.rch), 32'(exp_ch(drain_order[i])));
      end
      checkOutput("drain_irq_low", 32'(fifo_if.irq), 32'd0);
      t++;
      applyStimulus(1'b1, 1'b0, t);
      checkOutput("drain_empty", 32'(fifo_if.empty), 32'd1);
      checkOutput("drain_level", 32'(fifo_if.level), 32'd0);
      checkOutput("empty_rdata_hold", 32'(fifo_if.rdata), 32'(exp_sample(9)));
      t += 3;
      applyStimulus(1'b1, 1'b0, t);
      checkOutput("pop_empty_ignored", 32'(fifo_if.level), 32'd0);

      startRun(5);
      runTo(43);
      checkOutput("abort_sck_high", 32'(i2s_clk), 32'd1);
      en = 1'b0;
      runTo(44);
      checkOutput("abort_sck", 32'(i2s_clk), 32'd0);
      checkOutput("abort_ws", 32'(ws), 32'd0);
      runTo(400);
      checkOutput("abort_no_push", 32'(fifo_if.empty), 32'd1);

      startRun(12);
      runTo(P0-1); checkOutput("restart_empty", 32'(fifo_if.empty), 32'd1);
      runTo(P0);
      checkOutput("restart_push", 32'(fifo_if.empty), 32'd0);
      checkOutput("restart_rdata", 32'(fifo_if.rdata), 32'(word_l[12]));
      checkOutput("restart_rch", 32'(fifo_if.rch), 32'd0);
      en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
